// File: rtl/cfa_pkg.sv
// -----------------------------------------------------------------------------
// cfa_pkg
// Shared definitions for the CFA gradient pipeline:
//   - clog2 helper (ceiling log2, constant-foldable)
//   - sum_w / grad_w width derivations used by the pipeline and its sub-module
//   - window-orientation mode encoding (row sums vs column sums)
// -----------------------------------------------------------------------------
package cfa_pkg;

    localparam logic MODE_ROW = 1'b0;
    localparam logic MODE_COL = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Width of one line sum: K pixels of pix_w bits each.
    function automatic int unsigned sum_w(input int unsigned pix_w, input int unsigned k);
        return pix_w + clog2(k);
    endfunction

    // Width of the gradient: K-1 absolute differences of sum_w bits each.
    function automatic int unsigned grad_w(input int unsigned pix_w, input int unsigned k);
        return sum_w(pix_w, k) + clog2(k - 1);
    endfunction

endpackage

// File: rtl/cfa_abs_diff.sv
// -----------------------------------------------------------------------------
// cfa_abs_diff
// Combinational unsigned absolute difference |a - b|.
// Ports:
//   a_i   [SUM_W-1:0]  operand a
//   b_i   [SUM_W-1:0]  operand b
//   y_o   [SUM_W-1:0]  |a - b|
// -----------------------------------------------------------------------------
module cfa_abs_diff #(
    parameter int unsigned SUM_W = 15
) (
    input  logic [SUM_W-1:0] a_i,
    input  logic [SUM_W-1:0] b_i,
    output logic [SUM_W-1:0] y_o
);

    assign y_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/cfa_grad_pipe.sv
// -----------------------------------------------------------------------------
// cfa_grad_pipe
// Three-stage valid/ready pipeline computing K line sums (rows or columns) of
// a KxK pixel window and the gradient sum_{i=1..K-1} |e_i - e_(i-1)|.
//   S1: capture window + mode
//   S2: line sums
//   S3: absolute differences, accumulate, (optional) clip -> output registers
//
// Optional build macro: CFA_GRAD_CLIP_EN -- clip grad_out to GRAD_MAX in S3.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (priority over start)
//   start      single-cycle flush of all stages and win_cnt clear
//   in_valid   window valid
//   in_ready   window accepted when in_valid && in_ready
//   in_win     [K*K*PIX_W] row-major window, pixel[r][c] at index r*K+c
//   mode       0 = row sums, 1 = column sums (sampled with the window)
//   out_valid  result valid
//   out_ready  downstream accept
//   sums       [K*SUM_W] e0..e(K-1), LSB first
//   grad_out   [GRAD_W] gradient
//   win_cnt    [16] results delivered since reset/start (wraps)
// -----------------------------------------------------------------------------
module cfa_grad_pipe
    import cfa_pkg::*;
#(
    parameter int unsigned PIX_W    = 12,
    parameter int unsigned K        = 5,
    parameter int unsigned GRAD_MAX = 65535,
    localparam int unsigned SUM_W   = sum_w(PIX_W, K),
    localparam int unsigned GRAD_W  = grad_w(PIX_W, K)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [K*K*PIX_W-1:0]   in_win,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [K*SUM_W-1:0]     sums,
    output logic [GRAD_W-1:0]      grad_out,
    output logic [15:0]            win_cnt
);

    localparam int unsigned WIN_W = K * K * PIX_W;

    if (K < 3 || K > 9 || GRAD_MAX == 0) begin : g_bad_param
        $error("cfa_grad_pipe: K must be 3..9 and GRAD_MAX nonzero");
    end

    // Stage registers
    logic                  s1_v_q, s1_v_d;
    logic [WIN_W-1:0]      s1_win_q;
    logic                  s1_mode_q;

    logic                  s2_v_q, s2_v_d;
    logic [K*SUM_W-1:0]    s2_sums_q, s2_sums_d;

    logic                  s3_v_q, s3_v_d;
    logic [K*SUM_W-1:0]    s3_sums_q;
    logic [GRAD_W-1:0]     s3_grad_q, s3_grad_d;

    logic [15:0]           cnt_q, cnt_d;

    // Handshake / advance terms: a stage moves only when its successor is
    // empty or moving in the same cycle.
    logic out_fire, adv3, adv2, acc_in;

    assign out_fire = s3_v_q & out_ready;
    assign adv3     = s2_v_q & (~s3_v_q | out_ready);
    assign adv2     = s1_v_q & (~s2_v_q | adv3);
    assign in_ready = ~rst & ~start & (~s1_v_q | adv2);
    assign acc_in   = in_valid & in_ready;

    always_comb begin
        s1_v_d = acc_in ? 1'b1 : (adv2 ? 1'b0 : s1_v_q);
        s2_v_d = adv2   ? 1'b1 : (adv3 ? 1'b0 : s2_v_q);
        s3_v_d = adv3   ? 1'b1 : (out_fire ? 1'b0 : s3_v_q);
        cnt_d  = out_fire ? cnt_q + 16'd1 : cnt_q;
    end

    // S2: line sums; mode selects whether line i walks a row or a column.
    logic [SUM_W-1:0] line_acc;
    int unsigned      idx;

    always_comb begin
        s2_sums_d = '0;
        line_acc  = '0;
        idx       = 0;
        for (int unsigned i = 0; i < K; i++) begin
            line_acc = '0;
            for (int unsigned j = 0; j < K; j++) begin
                case (s1_mode_q)
                    MODE_ROW: idx = i * K + j;
                    MODE_COL: idx = j * K + i;
                    default:  idx = i * K + j;
                endcase
                line_acc = line_acc + SUM_W'(s1_win_q[idx*PIX_W +: PIX_W]);
            end
            s2_sums_d[i*SUM_W +: SUM_W] = line_acc;
        end
    end

    // S3: adjacent-line absolute differences and their sum.
    logic [SUM_W-1:0] diff [K-1];

    for (genvar g = 0; g < K - 1; g++) begin : g_diff
        cfa_abs_diff #(
            .SUM_W(SUM_W)
        ) u_abs (
            .a_i(s2_sums_q[(g+1)*SUM_W +: SUM_W]),
            .b_i(s2_sums_q[g*SUM_W +: SUM_W]),
            .y_o(diff[g])
        );
    end

    logic [GRAD_W-1:0] grad_sum;

    always_comb begin
        grad_sum = '0;
        for (int unsigned i = 0; i < K - 1; i++) begin
            grad_sum = grad_sum + GRAD_W'(diff[i]);
        end
`ifdef CFA_GRAD_CLIP_EN
        // Compare at 64 bits so a GRAD_MAX above the GRAD_W range never clips.
        s3_grad_d = (64'(grad_sum) > 64'(GRAD_MAX)) ? GRAD_W'(GRAD_MAX) : grad_sum;
`else
        s3_grad_d = grad_sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_win_q  <= '0;
            s1_mode_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_sums_q <= '0;
            s3_v_q    <= 1'b0;
            s3_sums_q <= '0;
            s3_grad_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (start) begin
                s1_v_q <= 1'b0;
                s2_v_q <= 1'b0;
                s3_v_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                s1_v_q <= s1_v_d;
                s2_v_q <= s2_v_d;
                s3_v_q <= s3_v_d;
                cnt_q  <= cnt_d;
            end
            if (acc_in) begin
                s1_win_q  <= in_win;
                s1_mode_q <= mode;
            end
            if (adv2) s2_sums_q <= s2_sums_d;
            if (adv3) begin
                s3_sums_q <= s2_sums_q;
                s3_grad_q <= s3_grad_d;
            end
        end
    end

    assign out_valid = s3_v_q;
    assign sums      = s3_sums_q;
    assign grad_out  = s3_grad_q;
    assign win_cnt   = cnt_q;

endmodule

// File: tb/tb_cfa_grad_pipe.sv
// -----------------------------------------------------------------------------
// tb_cfa_grad_pipe
// Directed-vector bench for cfa_grad_pipe (K=5, PIX_W=12). Expected sums and
// gradients are hand-computed constants or simple closed forms.
// -----------------------------------------------------------------------------
module tb_cfa_grad_pipe;

    localparam int unsigned PIX_W  = 12;
    localparam int unsigned K      = 5;
    localparam int unsigned SUM_W  = 15;
    localparam int unsigned GRAD_W = 17;
    localparam int unsigned WIN_W  = K * K * PIX_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIN_W-1:0]     in_win;
    logic                 mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [K*SUM_W-1:0]   sums;
    logic [GRAD_W-1:0]    grad_out;
    logic [15:0]          win_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    cfa_grad_pipe #(
        .PIX_W(PIX_W),
        .K(K),
        .GRAD_MAX(65535)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_win(in_win),
        .mode(mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sums(sums),
        .grad_out(grad_out),
        .win_cnt(win_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // kind 0: all pixels = arg; 1: 1000*r; 2: odd rows 4095, even rows 0;
    // 3: 10*c + r; other: arg*r
    function automatic logic [WIN_W-1:0] win_fn(input int unsigned kind, input int unsigned arg);
        logic [WIN_W-1:0] w;
        int unsigned v;
        w = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                case (kind)
                    0:       v = arg;
                    1:       v = 1000 * r;
                    2:       v = (r % 2 == 1) ? 4095 : 0;
                    3:       v = 10 * c + r;
                    default: v = arg * r;
                endcase
                w[(r*K+c)*PIX_W +: PIX_W] = PIX_W'(v);
            end
        end
        return w;
    endfunction

    function automatic logic [K*SUM_W-1:0] pack5(input int unsigned e0, input int unsigned e1,
                                                  input int unsigned e2, input int unsigned e3,
                                                  input int unsigned e4);
        logic [K*SUM_W-1:0] s;
        s = {SUM_W'(e4), SUM_W'(e3), SUM_W'(e2), SUM_W'(e1), SUM_W'(e0)};
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one window with out_ready high; check 3-edge latency, results and
    // the delivered count.
    task automatic send_win(input string tag, input logic [WIN_W-1:0] w, input logic m,
                            input logic [K*SUM_W-1:0] exp_s, input logic [GRAD_W-1:0] exp_g);
        in_valid  = 1'b1;
        in_win    = w;
        mode      = m;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_win   = '0;
        for (int i = 0; i < 2; i++) begin
            check({tag, "_early_valid"}, out_valid, 0);
            step();
        end
        check({tag, "_valid"}, out_valid, 1);
        for (int i = 0; i < K; i++) begin
            check({tag, "_e"}, sums[i*SUM_W +: SUM_W], exp_s[i*SUM_W +: SUM_W]);
        end
        check({tag, "_grad"}, grad_out, exp_g);
        exp_cnt++;
        step();
        check({tag, "_win_cnt"}, win_cnt, exp_cnt);
        check({tag, "_drained"}, out_valid, 0);
    endtask

    int sent;
    int got;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_win    = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sums", sums, 0);
        check("rst_grad", grad_out, 0);
        check("rst_win_cnt", win_cnt, 0);
        rst = 1'b0;
        step();

        send_win("flat", win_fn(0, 100), 1'b0, pack5(500, 500, 500, 500, 500), 0);
        send_win("ramp_row", win_fn(1, 0), 1'b0, pack5(0, 5000, 10000, 15000, 20000), 20000);
        send_win("ramp_col", win_fn(1, 0), 1'b1, pack5(10000, 10000, 10000, 10000, 10000), 0);
`ifdef CFA_GRAD_CLIP_EN
        send_win("alt_row", win_fn(2, 0), 1'b0, pack5(0, 20475, 0, 20475, 0), 65535);
`else
        send_win("alt_row", win_fn(2, 0), 1'b0, pack5(0, 20475, 0, 20475, 0), 81900);
`endif
        send_win("asym_row", win_fn(3, 0), 1'b0, pack5(100, 105, 110, 115, 120), 20);
        send_win("asym_col", win_fn(3, 0), 1'b1, pack5(10, 60, 110, 160, 210), 200);

        // A result handshaked in the start cycle is not counted.
        in_valid  = 1'b1;
        in_win    = win_fn(0, 1);
        mode      = 1'b0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        check("start_hs_valid", out_valid, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_hs_cnt", win_cnt, 0);
        check("start_hs_out_valid", out_valid, 0);
        exp_cnt = 0;

        // Backpressure: out_ready low for 5 cycles, 6 windows offered back-to-back.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            in_win    = win_fn(4, sent + 1);
            mode      = 1'b0;
            #1;
            if (cyc == 3) begin
                check("bp_in_ready_full", in_ready, 0);
                check("bp_accepted", sent, 3);
            end
            if (cyc == 3 || cyc == 4) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_grad", grad_out, 20);
                check("bp_hold_e4", sums[4*SUM_W +: SUM_W], 20);
            end
            if (out_valid && out_ready) begin
                check("bp_order_grad", grad_out, 20 * (got + 1));
                check("bp_order_e1", sums[SUM_W +: SUM_W], 5 * (got + 1));
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_results", got, 6);
        check("bp_win_cnt", win_cnt, 6);
        exp_cnt = 6;

        // Start with two windows in flight and a third offered.
        in_valid = 1'b1;
        in_win   = win_fn(4, 7);
        step();
        in_win = win_fn(4, 8);
        step();
        start  = 1'b1;
        in_win = win_fn(4, 9);
        #1;
        check("start_in_ready", in_ready, 0);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_out_valid", out_valid, 0);
        check("start_win_cnt", win_cnt, 0);
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            check("start_flushed", out_valid, 0);
            step();
        end
        send_win("post_start", win_fn(3, 0), 1'b1, pack5(10, 60, 110, 160, 210), 200);

        // Reset mid-stream.
        in_valid = 1'b1;
        in_win   = win_fn(1, 0);
        mode     = 1'b0;
        step();
        step();
        step();
        check("mid_valid_before_rst", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        step();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sums", sums, 0);
        check("mid_rst_grad", grad_out, 0);
        check("mid_rst_win_cnt", win_cnt, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_cnt  = 0;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_idle", out_valid, 0);
            step();
        end
        send_win("post_rst", win_fn(1, 0), 1'b0, pack5(0, 5000, 10000, 15000, 20000), 20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cfa_grad_pipe.md
CFA_GRAD_PIPE -- requirements
Module: cfa_grad_pipe

Interface
REQ-001 SHALL have parameter PIX_W, default 12: pixel width, unsigned.
REQ-002 SHALL have parameter K, default 5: window side length, range 3..9.
REQ-003 SHALL have parameter GRAD_MAX, default 65535: clip ceiling, used only under CFA_GRAD_CLIP_EN.
REQ-004 SHALL derive SUM_W = PIX_W + clog2(K) and GRAD_W = SUM_W + clog2(K-1); defaults give 15 and 17.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1: single-cycle flush and counter clear.
REQ-008 SHALL have port in_valid, input, 1: window valid.
REQ-009 SHALL have port in_ready, output, 1: window accepted when in_valid && in_ready.
REQ-010 SHALL have port in_win, input, K*K*PIX_W: row-major window, pixel [r][c] at index r*K+c, LSB first.
REQ-011 SHALL have port mode, input, 1: 0 = row sums, 1 = column sums; sampled with the window.
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accept.
REQ-014 SHALL have port sums, output, K*SUM_W: e0..e(K-1), LSB first.
REQ-015 SHALL have port grad_out, output, GRAD_W: gradient.
REQ-016 SHALL have port win_cnt, output, 16: count of results delivered since reset or start.

Function
REQ-017 SHALL compute e_i as the exact unsigned sum of row i (mode 0) or column i (mode 1).
REQ-018 SHALL compute grad_out = sum over i=1..K-1 of |e_i - e_(i-1)|, exact, no overflow at GRAD_W.
REQ-019 SHALL be a 3-stage pipeline (S1 capture, S2 sums, S3 abs-diff/accumulate), each stage with its own valid bit.
REQ-020 SHALL deliver the result 3 cycles after acceptance when out_ready is held high, at one result per cycle throughput.
REQ-021 SHALL advance a stage only when the next stage is empty or advancing in the same cycle; in_ready = !S1 valid || S1 advancing.
REQ-022 SHALL hold sums, grad_out and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL buffer at most 3 results under backpressure, with no loss, duplication or reordering.
REQ-024 SHALL increment win_cnt on each out_valid && out_ready, wrapping from 65535 to 0.
REQ-025 SHALL respond to start by clearing all stage valids and win_cnt on the next edge; in_ready is 0 while start is high, and a result handshaked in that same cycle is not counted.

Reset
REQ-026 SHALL, while rst is high, force in_ready=0, out_valid=0, sums=0, grad_out=0 and win_cnt=0 at every edge.
REQ-027 SHALL give rst priority over start; reset mid-stream discards all in-flight windows.

Configuration
REQ-028 SHALL, when CFA_GRAD_CLIP_EN is defined, output grad_out = min(grad, GRAD_MAX) in S3 with no added latency; when it is undefined, output the full-width grad and ignore GRAD_MAX.

Structure
REQ-029 SHALL place the clog2 helper, the SUM_W/GRAD_W derivation functions and the mode encoding constants in the shared package cfa_pkg.
REQ-030 SHALL implement |a-b| in a single combinational sub-module cfa_abs_diff (width parameter SUM_W), instantiated K-1 times.

Verification (K=5, PIX_W=12)
REQ-031 SHALL cover: all pixels 100, mode 0, out_ready=1 -> 3 cycles later every e_i=500, grad_out=0, win_cnt=1.
REQ-032 SHALL cover: row r pixels = 1000*r, mode 0 -> e = 0,5000,10000,15000,20000, grad_out=20000; the same window with mode 1 -> every e_i=10000, grad_out=0.
REQ-033 SHALL cover: rows alternating 0/4095 -> e alternating 0/20475, grad_out=81900; with CFA_GRAD_CLIP_EN and GRAD_MAX=65535 -> grad_out=65535.
REQ-034 SHALL cover: 6 back-to-back windows with out_ready=0 for 5 cycles -> in_ready drops after 3 acceptances, then all 6 results emerge in order, win_cnt=6.
REQ-035 SHALL cover: start asserted with 2 windows in flight and in_valid=1 -> next cycle out_valid=0 and win_cnt=0, the start-cycle window is not accepted, and the next window has a fresh 3-cycle latency.
REQ-036 SHALL cover: rst asserted mid-stream -> all outputs 0 at the next edge; the first window after rst release has 3-cycle latency.
